// File: rtl/node_mesh_proc_if.sv
// node_mesh_proc_if: channel and result handshake bundle.
// master drives the input words and out_ready; slave is the node.
interface node_mesh_proc_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
);
    localparam int CW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/node_mesh_proc.sv
// node_mesh_proc: gathers one word per enabled channel and reduces it
// (SUM/MAX/XOR) or forwards one word round-robin (ROUTE).
module node_mesh_proc #(
    parameter int WIDTH  = 4,
    parameter int NCH    = 4,
    parameter int OCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [NCH-1:0]      chan_en,
    input  logic                rnd,
    node_mesh_proc_if.slave     bus,
    output logic                busy,
    output logic [OCNT_W-1:0]   op_count
);
    localparam int CW = $clog2(NCH);

    localparam logic [1:0] M_ROUTE = 2'd0;
    localparam logic [1:0] M_SUM   = 2'd1;
    localparam logic [1:0] M_MAX   = 2'd2;
    localparam logic [1:0] M_XOR   = 2'd3;

    typedef enum logic [1:0] {
        S_START,
        S_COLLECT,
        S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [NCH-1:0]      en_q, en_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [NCH-1:0]      got_q, got_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic [OCNT_W-1:0]   cnt_q, cnt_d;

    logic [NCH-1:0]      rdy;
    logic [NCH-1:0]      hs;
    logic                vld;
    logic [WIDTH-1:0]    word [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign word[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    function automatic logic [WIDTH-1:0] fold(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (m)
            M_SUM:   r = a + b;
            M_MAX:   r = (b > a) ? b : a;
            M_XOR:   r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Pointer advance modulo NCH; NCH need not be a power of two.
    function automatic logic [CW-1:0] rr_step(
        input logic [CW-1:0] p,
        input logic          two
    );
        logic [CW:0] s;
        s = {1'b0, p} + (two ? (CW+1)'(2) : (CW+1)'(1));
        if (s >= (CW+1)'(NCH))
            s = s - (CW+1)'(NCH);
        return s[CW-1:0];
    endfunction

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        en_d    = en_q;
        acc_d   = acc_q;
        got_d   = got_q;
        rr_d    = rr_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        rdy     = '0;
        hs      = '0;
        vld     = 1'b0;
        unique case (state_q)
            S_START: begin
                mode_d  = mode;
                en_d    = chan_en;
                acc_d   = '0;
                got_d   = '0;
                chan_d  = '0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (mode_q == M_ROUTE) begin
                    rdy = (NCH'(1) << rr_q) & en_q;
                    if (en_q[rr_q] && bus.in_valid[rr_q]) begin
                        acc_d   = word[rr_q];
                        chan_d  = rr_q;
                        rr_d    = rr_step(rr_q, rnd);
                        state_d = S_EMIT;
                    end else begin
                        rr_d = rr_step(rr_q, 1'b0);
                    end
                end else begin
                    rdy = en_q & ~got_q;
                    hs  = rdy & bus.in_valid;
                    for (int i = 0; i < NCH; i++) begin
                        if (hs[i])
                            acc_d = fold(mode_q, acc_d, word[i]);
                    end
                    got_d = got_q | hs;
                    // An empty mask never completes.
                    if (en_q != '0 && got_d == en_q)
                        state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                vld = 1'b1;
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            mode_q  <= '0;
            en_q    <= '0;
            acc_q   <= '0;
            got_q   <= '0;
            rr_q    <= '0;
            chan_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            acc_q   <= acc_d;
            got_q   <= got_d;
            rr_q    <= rr_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_data  = acc_q;
    assign bus.out_chan  = chan_q;
    assign op_count      = cnt_q;
    assign busy          = (state_q == S_COLLECT) && (got_q != '0)
                           && (mode_q != M_ROUTE);
endmodule

// File: tb/tb_node_mesh_proc.sv
// tb_node_mesh_proc: directed vectors for node_mesh_proc.
// Expected values are hand-computed constants.
module tb_node_mesh_proc;
    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] chan_en;
    logic       rnd;
    logic       busy;
    logic [7:0] op_count;

    int nchk = 0;
    int nerr = 0;
    int exp_cnt = 0;

    node_mesh_proc_if #(.WIDTH(4), .NCH(4)) bus ();

    node_mesh_proc #(.WIDTH(4), .NCH(4), .OCNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .chan_en  (chan_en),
        .rnd      (rnd),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [3:0] v);
        bus.in_data[ch*4 +: 4] = v;
        bus.in_valid = 4'(1) << ch;
        tick();
        bus.in_valid = '0;
    endtask

    task automatic start_op(input logic [1:0] m, input logic [3:0] e);
        mode    = m;
        chan_en = e;
        tick();
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("vld_drop", 32'(bus.out_valid), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.out_valid), 1);
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [3:0] e);
        mode    = m;
        chan_en = e;
        rst_n   = 1'b0;
        #1;
        chk("rst_rdy",  32'(bus.in_ready), 0);
        chk("rst_vld",  32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_chan", 32'(bus.out_chan), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt",  32'(op_count), 0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] seq0 [5];
        logic [1:0] seq1 [4];
        seq0 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq1 = '{2'd0, 2'd2, 2'd0, 2'd2};
        rst_n         = 1'b0;
        mode          = 2'd1;
        chan_en       = 4'hF;
        rnd           = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // SUM over four channels, one per cycle: 4+5+6+3 = 18 -> 2
        do_reset(2'd1, 4'hF);
        start_op(2'd1, 4'hF);
        chk("sum_rdy0", 32'(bus.in_ready), 32'hF);
        send(0, 4'd4);
        chk("sum_busy", 32'(busy), 1);
        chk("sum_rdy1", 32'(bus.in_ready), 32'hE);
        send(1, 4'd5);
        send(2, 4'd6);
        send(3, 4'd3);
        chk("sum_vld",  32'(bus.out_valid), 1);
        chk("sum_data", 32'(bus.out_data), 32'h2);
        chk("sum_chan", 32'(bus.out_chan), 0);
        chk("sum_rdyE", 32'(bus.in_ready), 0);
        accept();

        // MAX with mask 0101; ch1 valid but disabled
        start_op(2'd2, 4'b0101);
        chk("max_rdy", 32'(bus.in_ready), 32'h5);
        bus.in_data  = {4'h0, 4'h3, 4'hF, 4'h9};
        bus.in_valid = 4'b0111;
        tick();
        bus.in_valid = '0;
        chk("max_vld",  32'(bus.out_valid), 1);
        chk("max_data", 32'(bus.out_data), 32'h9);
        accept();

        // XOR A^5 held off by out_ready=0 for 5 cycles
        start_op(2'd3, 4'b0011);
        bus.in_data  = {4'h0, 4'h0, 4'h5, 4'hA};
        bus.in_valid = 4'b0011;
        tick();
        bus.in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            chk("xor_vld",  32'(bus.out_valid), 1);
            chk("xor_data", 32'(bus.out_data), 32'hF);
            chk("xor_rdy",  32'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid = '0;
        accept();

        // ROUTE rnd=0: channels 0,1,2,3,0
        bus.in_data  = {4'hB, 4'hA, 4'h9, 4'h8};
        bus.in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            start_op(2'd0, 4'hF);
            chk("rt_busy", 32'(busy), 0);
            tick();
            chk("rt_vld",  32'(bus.out_valid), 1);
            chk("rt_chan", 32'(bus.out_chan), 32'(seq0[k]));
            chk("rt_data", 32'(bus.out_data), 32'(seq0[k]) + 8);
            accept();
        end

        // ROUTE rnd=1 from a fresh pointer: 0,2,0,2
        do_reset(2'd0, 4'hF);
        rnd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_op(2'd0, 4'hF);
            tick();
            chk("rr2_vld",  32'(bus.out_valid), 1);
            chk("rr2_chan", 32'(bus.out_chan), 32'(seq1[k]));
            accept();
        end
        rnd = 1'b0;

        // ROUTE with only ch3 enabled: pointer walks 0..3
        start_op(2'd0, 4'b1000);
        chk("rs_rdy0", 32'(bus.in_ready), 0);
        wait_valid("rs_vld");
        chk("rs_chan", 32'(bus.out_chan), 3);
        chk("rs_data", 32'(bus.out_data), 32'hB);
        bus.in_valid = '0;
        accept();

        // Reset in the middle of a SUM, then a clean SUM 7+7+7+1 -> 6
        start_op(2'd1, 4'hF);
        send(0, 4'd1);
        send(1, 4'd2);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_acc",  32'(bus.out_data), 32'h3);
        do_reset(2'd1, 4'hF);
        start_op(2'd1, 4'hF);
        send(0, 4'd7);
        send(1, 4'd7);
        send(2, 4'd7);
        send(3, 4'd1);
        chk("rs2_vld",  32'(bus.out_valid), 1);
        chk("rs2_data", 32'(bus.out_data), 32'h6);
        accept();

        // Empty mask: stuck in COLLECT, later mask changes ignored
        do_reset(2'd1, 4'h0);
        start_op(2'd1, 4'h0);
        chan_en      = 4'hF;
        bus.in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            chk("en0_rdy", 32'(bus.in_ready), 0);
            chk("en0_vld", 32'(bus.out_valid), 0);
            tick();
        end
        chk("en0_cnt", 32'(op_count), 0);
        bus.in_valid = '0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
